prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 194 +++++++++++++++++++
 tb/tb_prog_loader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
//  Module   : prog_loader
//  Purpose  : Receives a little-endian byte stream (16-bit word count followed
//             by packed 32-bit words), writes the words into instruction
//             memory, and holds the CPU in reset until the load completes.
//  Revision : 1.0 - initial release
// ============================================================================
module prog_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       words_loaded
);

    // Word count limit; 17 bits so a 16-bit address space still compares correctly.
    localparam logic [16:0] c_DEPTH = 17'(1 << ADDR_W);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN0  = 3'd1,
        S_LEN1  = 3'd2,
        S_DATA  = 3'd3,
        S_FLUSH = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [15:0]         r_len;
    logic [15:0]         w_len_nxt;
    logic [1:0]          r_lane;
    logic [1:0]          w_lane_nxt;
    logic [23:0]         r_acc;
    logic [23:0]         w_acc_nxt;

    logic                w_in_ready_nxt;
    logic                w_we_nxt;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [31:0]         w_wdata_nxt;
    logic                w_hold_nxt;
    logic                w_busy_nxt;
    logic                w_done_nxt;
    logic                w_err_nxt;
    logic [15:0]         w_wl_nxt;

    logic                w_xfer;
    logic [15:0]         w_len_full;

    assign w_xfer     = in_valid & in_ready;
    // Full word count as it becomes known when the high length byte arrives.
    assign w_len_full = {in_data, r_len[7:0]};

    // State and registered outputs; reset abandons any partial word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_len        <= 16'd0;
            r_lane       <= 2'd0;
            r_acc        <= 24'd0;
            in_ready     <= 1'b0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= 32'd0;
            cpu_hold     <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= 16'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_len        <= w_len_nxt;
            r_lane       <= w_lane_nxt;
            r_acc        <= w_acc_nxt;
            in_ready     <= w_in_ready_nxt;
            imem_we      <= w_we_nxt;
            imem_addr    <= w_addr_nxt;
            imem_wdata   <= w_wdata_nxt;
            cpu_hold     <= w_hold_nxt;
            busy         <= w_busy_nxt;
            done         <= w_done_nxt;
            err          <= w_err_nxt;
            words_loaded <= w_wl_nxt;
        end
    end

    // Next-state and next-output decode; every output is a register, so this
    // computes the value each output takes after the coming edge.
    always_comb begin
        w_state_nxt    = r_state;
        w_len_nxt      = r_len;
        w_lane_nxt     = r_lane;
        w_acc_nxt      = r_acc;
        w_in_ready_nxt = in_ready;
        w_we_nxt       = 1'b0;
        w_addr_nxt     = imem_addr;
        w_wdata_nxt    = imem_wdata;
        w_hold_nxt     = cpu_hold;
        w_busy_nxt     = busy;
        w_done_nxt     = done;
        w_err_nxt      = err;
        w_wl_nxt       = words_loaded;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt    = S_LEN0;
                    w_lane_nxt     = 2'd0;
                    w_acc_nxt      = 24'd0;
                    w_in_ready_nxt = 1'b1;
                    w_busy_nxt     = 1'b1;
                    w_hold_nxt     = 1'b1;
                    w_done_nxt     = 1'b0;
                    w_err_nxt      = 1'b0;
                    w_wl_nxt       = 16'd0;
                end
            end
            S_LEN0: begin
                if (w_xfer) begin
                    w_len_nxt   = {8'h00, in_data};
                    w_state_nxt = S_LEN1;
                end
            end
            S_LEN1: begin
                if (w_xfer) begin
                    w_len_nxt = w_len_full;
                    if (w_len_full == 16'd0) begin
                        // Empty program: release the CPU straight away.
                        w_state_nxt    = S_DONE;
                        w_in_ready_nxt = 1'b0;
                        w_busy_nxt     = 1'b0;
                        w_done_nxt     = 1'b1;
                        w_hold_nxt     = 1'b0;
                    end else if ({1'b0, w_len_full} > c_DEPTH) begin
                        // Program larger than memory: refuse it, CPU stays held.
                        w_state_nxt    = S_DONE;
                        w_in_ready_nxt = 1'b0;
                        w_busy_nxt     = 1'b0;
                        w_err_nxt      = 1'b1;
                    end else begin
                        w_state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_xfer) begin
                    if (r_lane == 2'd3) begin
                        // words_loaded doubles as the index of the word being built.
                        w_we_nxt    = 1'b1;
                        w_addr_nxt  = words_loaded[ADDR_W-1:0];
                        w_wdata_nxt = {in_data, r_acc};
                        w_wl_nxt    = words_loaded + 16'd1;
                        w_lane_nxt  = 2'd0;
                        if (words_loaded == (r_len - 16'd1)) begin
                            w_state_nxt    = S_FLUSH;
                            w_in_ready_nxt = 1'b0;
                        end
                    end else begin
                        w_lane_nxt = r_lane + 2'd1;
                        case (r_lane)
                            2'd0:    w_acc_nxt[7:0]   = in_data;
                            2'd1:    w_acc_nxt[15:8]  = in_data;
                            default: w_acc_nxt[23:16] = in_data;
                        endcase
                    end
                end
            end
            S_FLUSH: begin
                // Final write pulse is on the bus this cycle.
                w_state_nxt = S_DONE;
                w_busy_nxt  = 1'b0;
                w_done_nxt  = 1'b1;
                w_hold_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prog_loader
//  Purpose  : Self-checking bench for prog_loader: directed and randomized
//             loads compared against a byte-list reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk      = 1'b0;
    logic              reset    = 1'b1;
    logic              start    = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data  = 8'h00;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              err;
    logic [15:0]       words_loaded;

    int errors = 0;
    int checks = 0;

    logic [7:0]        stim[$];
    logic [ADDR_W-1:0] obs_addr[$];
    logic [31:0]       obs_data[$];

    prog_loader #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    // Record every cycle in which a write is on the bus.
    always @(negedge clk) begin
        if (imem_we) begin
            obs_addr.push_back(imem_addr);
            obs_data.push_back(imem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ":in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, ":imem_we"},  32'(imem_we), 32'd0);
        chk({tag, ":addr"},     32'(imem_addr), 32'd0);
        chk({tag, ":wdata"},    imem_wdata, 32'd0);
        chk({tag, ":cpu_hold"}, 32'(cpu_hold), 32'd1);
        chk({tag, ":busy"},     32'(busy), 32'd0);
        chk({tag, ":done"},     32'(done), 32'd0);
        chk({tag, ":err"},      32'(err), 32'd0);
        chk({tag, ":words"},    32'(words_loaded), 32'd0);
    endtask

    task automatic do_start(input string tag);
        @(negedge clk);
        start    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        obs_addr.delete();
        obs_data.delete();
        chk({tag, ":start_busy"},  32'(busy), 32'd1);
        chk({tag, ":start_ready"}, 32'(in_ready), 32'd1);
        chk({tag, ":start_hold"},  32'(cpu_hold), 32'd1);
        chk({tag, ":start_done"},  32'(done), 32'd0);
        chk({tag, ":start_err"},   32'(err), 32'd0);
        chk({tag, ":start_words"}, 32'(words_loaded), 32'd0);
    endtask

    // Present one byte; returns at the negedge before the edge that takes it.
    task automatic send_byte(input logic [7:0] b, input bit gaps, input bit rstart);
        bit sent  = 1'b0;
        int guard = 0;
        while (!sent && guard < 200) begin
            @(negedge clk);
            guard++;
            start = rstart && ($urandom_range(0, 3) == 0);
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
            end else begin
                in_valid = 1'b1;
                in_data  = b;
                sent     = in_ready;
            end
        end
        if (!sent) chk("byte_timeout", 32'd0, 32'd1);
    endtask

    // Reference model: derive the expected writes and outcome from the byte list.
    task automatic run_load(input bit gaps, input bit rstart, input string tag);
        int          n;
        bit          too_long;
        logic [31:0] exp_w[$];
        n        = int'(stim[0]) + 256 * int'(stim[1]);
        too_long = (n > DEPTH);
        if (!too_long) begin
            for (int i = 0; i < n; i++)
                exp_w.push_back({stim[2+4*i+3], stim[2+4*i+2], stim[2+4*i+1], stim[2+4*i]});
        end
        do_start(tag);
        foreach (stim[k]) send_byte(stim[k], gaps, rstart);
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
        if (too_long) begin
            chk({tag, ":err"},    32'(err), 32'd1);
            chk({tag, ":done"},   32'(done), 32'd0);
            chk({tag, ":hold"},   32'(cpu_hold), 32'd1);
            chk({tag, ":busy"},   32'(busy), 32'd0);
            chk({tag, ":ready"},  32'(in_ready), 32'd0);
            chk({tag, ":words"},  32'(words_loaded), 32'd0);
            chk({tag, ":writes"}, 32'(obs_addr.size()), 32'd0);
        end else if (n == 0) begin
            chk({tag, ":done"},   32'(done), 32'd1);
            chk({tag, ":hold"},   32'(cpu_hold), 32'd0);
            chk({tag, ":busy"},   32'(busy), 32'd0);
            chk({tag, ":err"},    32'(err), 32'd0);
            chk({tag, ":ready"},  32'(in_ready), 32'd0);
            chk({tag, ":words"},  32'(words_loaded), 32'd0);
            chk({tag, ":writes"}, 32'(obs_addr.size()), 32'd0);
        end else begin
            chk({tag, ":last_we"},    32'(imem_we), 32'd1);
            chk({tag, ":last_addr"},  32'(imem_addr), 32'(n - 1));
            chk({tag, ":last_data"},  imem_wdata, exp_w[n-1]);
            chk({tag, ":flush_done"}, 32'(done), 32'd0);
            chk({tag, ":flush_busy"}, 32'(busy), 32'd1);
            chk({tag, ":flush_rdy"},  32'(in_ready), 32'd0);
            chk({tag, ":words"},      32'(words_loaded), 32'(n));
            @(negedge clk);
            chk({tag, ":we_off"}, 32'(imem_we), 32'd0);
            chk({tag, ":done"},   32'(done), 32'd1);
            chk({tag, ":hold"},   32'(cpu_hold), 32'd0);
            chk({tag, ":busy"},   32'(busy), 32'd0);
            chk({tag, ":err"},    32'(err), 32'd0);
            chk({tag, ":writes"}, 32'(obs_addr.size()), 32'(n));
            for (int i = 0; i < n && i < obs_addr.size(); i++) begin
                chk({tag, ":addr"}, 32'(obs_addr[i]), 32'(i));
                chk({tag, ":data"}, obs_data[i], exp_w[i]);
            end
        end
    endtask

    task automatic load_basic_stim();
        stim = {8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hCD, 8'hAB, 8'h89};
    endtask

    initial begin
        // Asynchronous reset before any clock edge.
        #1 reset = 1'b0;
        #1 chk_reset_vals("por");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Two-word directed load.
        load_basic_stim();
        run_load(1'b0, 1'b0, "basic");

        // Empty program.
        stim = {8'h00, 8'h00};
        run_load(1'b0, 1'b0, "empty");

        // Too long (257 words); the following start must clear err.
        stim = {8'h01, 8'h01};
        run_load(1'b0, 1'b0, "toolong");

        // Directed load with valid bubbles and stray start pulses.
        load_basic_stim();
        run_load(1'b1, 1'b1, "bubbles");

        // Randomized short loads.
        for (int r = 0; r < 6; r++) begin
            int n = $urandom_range(1, 6);
            stim = {8'(n), 8'h00};
            for (int i = 0; i < 4 * n; i++) stim.push_back(8'($urandom));
            run_load(1'b1, 1'b1, "rand");
        end

        // Full-depth load: every address written once, no wrap.
        stim = {8'(DEPTH & 255), 8'(DEPTH >> 8)};
        for (int i = 0; i < 4 * DEPTH; i++) stim.push_back(8'($urandom));
        run_load(1'b0, 1'b0, "fulldepth");

        // Reset in the middle of the second word.
        load_basic_stim();
        do_start("midrst");
        for (int k = 0; k < 8; k++) send_byte(stim[k], 1'b0, 1'b0);
        @(posedge clk);
        #2 reset = 1'b0;
        in_valid = 1'b0;
        #1 chk_reset_vals("midrst");
        chk("midrst:writes", 32'(obs_addr.size()), 32'd1);
        if (obs_addr.size() > 0) begin
            chk("midrst:addr0", 32'(obs_addr[0]), 32'd0);
            chk("midrst:data0", obs_data[0], 32'h12345678);
        end
        @(negedge clk);
        reset = 1'b1;
        load_basic_stim();
        run_load(1'b0, 1'b0, "reload");

        // Reset while sitting in the done state, between clock edges.
        @(posedge clk);
        #3 reset = 1'b0;
        #1 chk_reset_vals("donerst");
        @(negedge clk);
        reset = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
